// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// State encoding and time-width constants.
package stopwatch_pkg;

    localparam int TIME_W           = 19;
    localparam int MAX_TIME_DEFAULT = 359999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    function automatic logic is_counting(input state_t s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_event.sv
// Key conditioning: 2-flop sync, optional debounce, fall-edge press pulse.
// Debounce stage enabled by defining STOPWATCH_DEBOUNCE_EN.
module key_event #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_key_n,
    output logic o_press
);

    logic [1:0] r_sync;
    logic       r_prev;
    logic       w_level;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("key_event: DEBOUNCE_CYCLES must be >= 1");
    end

    // bring the asynchronous key into the clock domain; idle level is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_key_n};
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_db;

    // level follows the synced key only after it differs for the full window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_db  <= 1'b1;
        end else if (r_sync[1] == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_db  <= r_sync[1];
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_level = r_db;
`else
    assign w_level = r_sync[1];
`endif

    // remember last level so only a high-to-low change makes an event
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_press = r_prev & ~w_level;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: key events, run/pause/lap FSM, tick prescaler, counter.
// Optional key debouncing via STOPWATCH_DEBOUNCE_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV        = 500000,
    parameter int MAX_TIME        = MAX_TIME_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_start_n,
    input  logic              key_lap_n,
    input  logic              key_clear_n,
    output logic [TIME_W-1:0] time_cs,
    output logic              run,
    output logic              paused,
    output logic              lap_hold,
    output logic              tick,
    output logic              wrap
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0] LIVE_MAX = TIME_W'(MAX_TIME);

    if (TICK_DIV < 1 || MAX_TIME < 0 || MAX_TIME >= (1 << TIME_W)) begin : g_bad_param
        $error("stopwatch_ctrl: TICK_DIV or MAX_TIME out of range");
    end

    state_t            r_state;
    logic [PRE_W-1:0]  r_pre;
    logic [TIME_W-1:0] r_live;
    logic [TIME_W-1:0] r_lap;

    logic w_start;
    logic w_lap;
    logic w_clear;
    logic w_counting;
    logic w_tick;
    logic w_top;

    key_event #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
        .clk     (clk),
        .reset   (reset),
        .i_key_n (key_start_n),
        .o_press (w_start)
    );

    key_event #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_lap (
        .clk     (clk),
        .reset   (reset),
        .i_key_n (key_lap_n),
        .o_press (w_lap)
    );

    key_event #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
        .clk     (clk),
        .reset   (reset),
        .i_key_n (key_clear_n),
        .o_press (w_clear)
    );

    assign w_counting = is_counting(r_state);
    assign w_tick     = w_counting && (r_pre == PRE_LAST);
    assign w_top      = (r_live == LIVE_MAX);

    // counting follows the current state; the case below may override it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_pre   <= '0;
            r_live  <= '0;
            r_lap   <= '0;
        end else begin
            if (w_counting) begin
                if (w_tick) begin
                    r_pre  <= '0;
                    r_live <= w_top ? '0 : r_live + 1'b1;
                end else begin
                    r_pre  <= r_pre + 1'b1;
                end
            end
            unique case (r_state)
                ST_IDLE: begin
                    r_pre <= '0;
                    if (w_start) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_start) begin
                        r_state <= ST_PAUSE;
                    end else if (w_lap) begin
                        r_state <= ST_LAP;
                        r_lap   <= r_live;
                    end
                end
                ST_LAP: begin
                    if (w_clear) begin
                        r_state <= ST_RUN;
                    end else if (w_start) begin
                        r_state <= ST_PAUSE;
                    end else if (w_lap) begin
                        r_lap <= r_live;
                    end
                end
                ST_PAUSE: begin
                    if (w_clear) begin
                        r_state <= ST_IDLE;
                        r_live  <= '0;
                        r_lap   <= '0;
                        r_pre   <= '0;
                    end else if (w_start) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign time_cs  = (r_state == ST_LAP) ? r_lap : r_live;
    assign run      = w_counting;
    assign paused   = (r_state == ST_PAUSE);
    assign lap_hold = (r_state == ST_LAP);
    assign tick     = w_tick;
    assign wrap     = w_tick & w_top;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: two instances (TICK_DIV=4 and a
// TICK_DIV=1 / MAX_TIME=9 wrap instance), checks sampled on falling edges.
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_start = 1'b1, a_lap = 1'b1, a_clear = 1'b1;
    logic        b_start = 1'b1;
    logic        b_lap = 1'b1, b_clear = 1'b1;

    logic [18:0] a_time, b_time;
    logic        a_run, a_paused, a_lhold, a_tick, a_wrap;
    logic        b_run, b_paused, b_lhold, b_tick, b_wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .TICK_DIV(4), .MAX_TIME(359999), .DEBOUNCE_CYCLES(5)
    ) dut_a (
        .clk(clk), .reset(reset),
        .key_start_n(a_start), .key_lap_n(a_lap), .key_clear_n(a_clear),
        .time_cs(a_time), .run(a_run), .paused(a_paused),
        .lap_hold(a_lhold), .tick(a_tick), .wrap(a_wrap)
    );

    stopwatch_ctrl #(
        .TICK_DIV(1), .MAX_TIME(9), .DEBOUNCE_CYCLES(5)
    ) dut_b (
        .clk(clk), .reset(reset),
        .key_start_n(b_start), .key_lap_n(b_lap), .key_clear_n(b_clear),
        .time_cs(b_time), .run(b_run), .paused(b_paused),
        .lap_hold(b_lhold), .tick(b_tick), .wrap(b_wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // drive selected keys low at a falling edge; return just after the
    // edge where the state changes, with keys released
    task automatic press_a(input bit s, input bit l, input bit c);
        a_start = ~s;
        a_lap   = ~l;
        a_clear = ~c;
        cyc(3);
        a_start = 1'b1;
        a_lap   = 1'b1;
        a_clear = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        cyc(2);
        chk("rst_time", a_time, 0);
        chk("rst_run", a_run, 0);
        chk("rst_paused", a_paused, 0);
        chk("rst_lap", a_lhold, 0);
        chk("rst_tick", a_tick, 0);
        chk("rst_wrap", a_wrap, 0);
        chk("rst_b_time", b_time, 0);
        reset = 1'b1;
        cyc(2);

`ifdef STOPWATCH_DEBOUNCE_EN
        a_start = 1'b0;
        cyc(3);
        a_start = 1'b1;
        cyc(12);
        chk("db_glitch_run", a_run, 0);
        a_start = 1'b0;
        cyc(7);
        chk("db_before", a_run, 0);
        cyc(1);
        chk("db_after", a_run, 1);
        a_start = 1'b1;
        cyc(10);
        chk("db_release_run", a_run, 1);
`else
        // IDLE -> RUN, first tick after TICK_DIV cycles
        press_a(1, 0, 0);
        chk("start_run", a_run, 1);
        chk("start_paused", a_paused, 0);
        chk("start_time", a_time, 0);
        chk("start_tick", a_tick, 0);
        cyc(2);
        chk("tick_early", a_tick, 0);
        cyc(1);
        chk("tick_first", a_tick, 1);
        chk("tick_first_time", a_time, 0);
        cyc(1);
        chk("after_tick_time", a_time, 1);
        chk("after_tick_tick", a_tick, 0);
        cyc(36);
        chk("run40_time", a_time, 10);
        chk("run40_paused", a_paused, 0);

        // pause with sub-tick phase 3 kept
        press_a(1, 0, 0);
        chk("pause_paused", a_paused, 1);
        chk("pause_run", a_run, 0);
        chk("pause_time", a_time, 10);
        cyc(20);
        chk("pause_hold_time", a_time, 10);
        chk("pause_hold_tick", a_tick, 0);
        press_a(1, 0, 0);
        chk("resume_run", a_run, 1);
        chk("resume_tick", a_tick, 1);
        chk("resume_time", a_time, 10);
        cyc(1);
        chk("resume_inc", a_time, 11);

        // lap: split frozen while live keeps counting
        press_a(0, 1, 0);
        chk("lap_hold", a_lhold, 1);
        chk("lap_run", a_run, 1);
        chk("lap_time", a_time, 11);
        cyc(8);
        chk("lap_frozen", a_time, 11);
        press_a(0, 1, 0);
        chk("lap2_time", a_time, 14);
        press_a(0, 0, 1);
        chk("lapclr_hold", a_lhold, 0);
        chk("lapclr_run", a_run, 1);
        chk("lapclr_time", a_time, 15);

        // pause edge coincides with a tick: old state still counts
        press_a(1, 0, 0);
        chk("pause_tick_paused", a_paused, 1);
        chk("pause_tick_time", a_time, 16);

        // start + clear together in PAUSE: clear wins
        press_a(1, 0, 1);
        chk("sc_run", a_run, 0);
        chk("sc_paused", a_paused, 0);
        chk("sc_lap", a_lhold, 0);
        chk("sc_time", a_time, 0);
        cyc(5);
        chk("idle_time", a_time, 0);
        chk("idle_tick", a_tick, 0);

        // async reset while in LAP
        press_a(1, 0, 0);
        press_a(0, 1, 0);
        chk("pre_rst_lap", a_lhold, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_run", a_run, 0);
        chk("arst_lap", a_lhold, 0);
        chk("arst_paused", a_paused, 0);
        chk("arst_time", a_time, 0);
        chk("arst_tick", a_tick, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(6);
        chk("post_rst_run", a_run, 0);

        // wrap instance: TICK_DIV=1, MAX_TIME=9
        b_start = 1'b0;
        cyc(3);
        b_start = 1'b1;
        chk("b_run", b_run, 1);
        chk("b_tick", b_tick, 1);
        chk("b_time0", b_time, 0);
        chk("b_wrap0", b_wrap, 0);
        cyc(9);
        chk("b_time9", b_time, 9);
        chk("b_wrap9", b_wrap, 1);
        cyc(1);
        chk("b_wrapped", b_time, 0);
        chk("b_wrap_end", b_wrap, 0);
        chk("b_tick_cont", b_tick, 1);
        cyc(1);
        chk("b_continue", b_time, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
